// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests
// under a credit limit, and queues returned {pc, instr} pairs for IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] FULL  = CW'(FQ_DEPTH);
    localparam logic [CW+1:0] LIMIT = (CW+2)'(FQ_DEPTH);
    localparam logic [31:0]   NOP   = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_tag [FQ_DEPTH];
    logic [AW-1:0] r_tag_wp;
    logic [AW-1:0] r_tag_rp;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_q_count;
    logic [31:0]   r_q_pc    [FQ_DEPTH];
    logic [31:0]   r_q_instr [FQ_DEPTH];
    logic [AW-1:0] r_q_wp;
    logic [AW-1:0] r_q_rp;

    logic [CW+1:0] w_inflight;
    logic          w_issue;
    logic          w_push;
    logic          w_rsp_drop;
    logic          w_pop;

    // Stale (to-be-dropped) fetches still hold a credit until they return.
    assign w_inflight = {2'b00, r_outstanding}
                      + {2'b00, r_q_count}
                      + {2'b00, r_drop_cnt};

    assign imem_req_valid = !rst && !redirect && (w_inflight < LIMIT);
    assign imem_req_addr  = r_fetch_pc;

    assign w_issue    = imem_req_valid && imem_req_ready;
    assign w_push     = imem_rsp_valid && (r_drop_cnt == '0) && !redirect;
    assign w_rsp_drop = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_pop      = fetch_valid && !stall && !redirect;

    assign fetch_valid = (r_q_count != '0);
    assign instr_out   = fetch_valid ? r_q_instr[r_q_rp] : NOP;
    assign pc_out      = fetch_valid ? r_q_pc[r_q_rp] : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_tag_wp      <= '0;
            r_tag_rp      <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_q_count     <= '0;
            r_q_wp        <= '0;
            r_q_rp        <= '0;
        end else if (redirect) begin
            r_fetch_pc    <= redirect_pc;
            r_tag_wp      <= '0;
            r_tag_rp      <= '0;
            r_outstanding <= '0;
            r_q_count     <= '0;
            r_q_wp        <= '0;
            r_q_rp        <= '0;
            r_drop_cnt    <= r_drop_cnt + r_outstanding
                           - (imem_rsp_valid ? ONE : '0);
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_tag_wp   <= r_tag_wp + AW'(1);
            end
            if (w_push) begin
                r_tag_rp <= r_tag_rp + AW'(1);
                r_q_wp   <= r_q_wp + AW'(1);
            end
            if (w_pop) begin
                r_q_rp <= r_q_rp + AW'(1);
            end
            if (w_rsp_drop) begin
                r_drop_cnt <= r_drop_cnt - ONE;
            end
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_push);
            r_q_count     <= r_q_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Payload storage needs no reset; validity lives in the counters above.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tag[r_tag_wp] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_pc[r_q_wp]    <= r_tag[r_tag_rp];
            r_q_instr[r_q_wp] <= imem_rsp_data;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(w_push && !w_pop && r_q_count == FULL)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed table, hand sequences and random traffic
// checked against a queue-based fetch model with an in-order memory model.
module tb_if_fetch_unit;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .fetch_valid(fetch_valid),
        .instr_out(instr_out),
        .pc_out(pc_out)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } fl_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } qe_t;

    typedef struct {
        bit          fv;
        logic [31:0] pc;
        bit          rv;
        logic [31:0] addr;
    } vec_t;

    fl_t         infl[$];
    qe_t         mq[$];
    logic [31:0] m_pc;
    int          cyc;
    int          last_due;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_pass = 0;
    int          n_tot = 0;

    logic        o_fv;
    logic        o_rv;
    logic [31:0] o_pc;
    logic [31:0] o_ins;
    logic [31:0] o_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_rsp_valid = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        imem_req_ready = 1'b0;
        infl.delete();
        mq.delete();
        m_pc = 32'h0;
        last_due = -1;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_instr", instr_out, 32'h13);
        chk("rst_pc", pc_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // One cycle: drive at negedge, compare at negedge+1, advance the model.
    task automatic step(input bit s, input bit r, input logic [31:0] rp,
                        input bit rd);
        bit  rspv;
        bit  rv_e;
        bit  pop;
        int  d;
        fl_t f;
        fl_t t;
        qe_t e;
        stall = s;
        redirect = r;
        redirect_pc = rp;
        imem_req_ready = rd;
        rspv = (infl.size() > 0) && (infl[0].due <= cyc);
        imem_rsp_valid = rspv;
        imem_rsp_data = rspv ? memf(infl[0].addr) : 32'($urandom);
        #1;
        o_fv = fetch_valid;
        o_rv = imem_req_valid;
        o_pc = pc_out;
        o_ins = instr_out;
        o_addr = imem_req_addr;
        rv_e = !r && (infl.size() + mq.size() < D);
        chk("req_valid", o_rv, rv_e);
        chk("req_addr", o_addr, m_pc);
        chk("fetch_valid", o_fv, mq.size() > 0);
        chk("pc_out", o_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
        chk("instr_out", o_ins, (mq.size() > 0) ? mq[0].ins : 32'h13);
        if (r) begin
            if (rspv) f = infl.pop_front();
            for (int i = 0; i < infl.size(); i++) begin
                t = infl[i];
                t.stale = 1'b1;
                infl[i] = t;
            end
            mq.delete();
            m_pc = rp;
        end else begin
            pop = (mq.size() > 0) && !s;
            if (pop) e = mq.pop_front();
            if (rspv) begin
                f = infl.pop_front();
                if (!f.stale) begin
                    e.pc = f.addr;
                    e.ins = memf(f.addr);
                    mq.push_back(e);
                end
            end
            if (rv_e && rd) begin
                d = cyc + $urandom_range(lat_max, lat_min);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                f.addr = m_pc;
                f.due = d;
                f.stale = 1'b0;
                infl.push_back(f);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        vec_t        tbl[8];
        logic [31:0] held;
        logic [31:0] prev;
        logic [31:0] a0;
        bit          held_fv;
        bit          got;
        bit          bad;
        bit          saw_fc;
        bit          done;
        bit          s;
        bit          r;
        bit          rd;
        logic [31:0] rp;

        tbl[0] = '{1'b0, 32'h0,  1'b1, 32'h0};
        tbl[1] = '{1'b0, 32'h0,  1'b1, 32'h4};
        tbl[2] = '{1'b1, 32'h0,  1'b0, 32'h8};
        tbl[3] = '{1'b1, 32'h4,  1'b1, 32'h8};
        tbl[4] = '{1'b0, 32'h0,  1'b1, 32'hC};
        tbl[5] = '{1'b1, 32'h8,  1'b0, 32'h10};
        tbl[6] = '{1'b1, 32'hC,  1'b1, 32'h10};
        tbl[7] = '{1'b0, 32'h0,  1'b1, 32'h14};

        lat_min = 1;
        lat_max = 1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            chk("tbl_fv", o_fv, tbl[i].fv);
            chk("tbl_pc", o_pc, tbl[i].pc);
            chk("tbl_rv", o_rv, tbl[i].rv);
            chk("tbl_addr", o_addr, tbl[i].addr);
            chk("tbl_instr", o_ins, tbl[i].fv ? memf(tbl[i].pc) : 32'h13);
        end

        step(1'b1, 1'b0, 32'h0, 1'b1);
        held = o_pc;
        held_fv = o_fv;
        chk("stall_head_valid", held_fv, 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (held_fv) chk("stall_hold_pc", o_pc, held);
        end
        chk("stall_no_credit", o_rv, 0);
        prev = held - 32'd4;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (o_fv) begin
                chk("stall_seq", o_pc, prev + 32'd4);
                prev = o_pc;
            end
        end

        lat_min = 3;
        lat_max = 3;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (infl.size() == 2) break;
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("two_in_flight", infl.size(), 2);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        got = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (o_fv && !got) begin
                chk("redir_first_pc", o_pc, 32'h100);
                got = 1'b1;
            end
            if (o_fv && (o_pc == 32'h8 || o_pc == 32'hC)) bad = 1'b1;
        end
        chk("redir_seen", got, 1);
        chk("redir_no_stale", bad, 0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (infl.size() > 0 && infl[0].due == cyc) break;
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        step(1'b1, 1'b1, 32'h200, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (o_fv && !got) begin
                chk("rsp_redir_first_pc", o_pc, 32'h200);
                got = 1'b1;
            end
        end
        chk("rsp_redir_seen", got, 1);

        lat_min = 2;
        lat_max = 2;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        a0 = o_addr;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            chk("rdy_addr_stable", o_addr, a0);
        end
        chk("rdy_drain_fv", o_fv, 0);
        chk("rdy_drain_instr", o_ins, 32'h13);

        lat_min = 1;
        lat_max = 1;
        do_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        saw_fc = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (saw_fc && !done) begin
                chk("wrap_addr", o_addr, 32'h0);
                done = 1'b1;
            end
            if (o_rv && o_addr == 32'hFFFF_FFFC) saw_fc = 1'b1;
        end
        chk("wrap_seen", done, 1);

        lat_min = 1;
        lat_max = 4;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                lat_min = 1;
                lat_max = 4;
            end
            s = ($urandom_range(99) < 30);
            r = ($urandom_range(99) < 5);
            rd = ($urandom_range(99) < 70);
            rp = ($urandom_range(3) == 0)
               ? (32'hFFFF_FFF0 | (32'($urandom_range(3)) << 2))
               : (32'($urandom) & 32'hFFFF_FFFC);
            step(s, r, rp, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
